// File: rtl/conv_acc_mem_if.sv
// Write/read/clear bus of the convolution result memory.
// The slave modport is the memory side; the master modport is the datapath side.
interface conv_acc_mem_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                  wr_en_i;
   logic                  acc_en_i;
   logic [ADDR_WIDTH-1:0] wr_addr_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic                  wr_ready_o;
   logic [ADDR_WIDTH-1:0] read_addr_i;
   logic [DATA_WIDTH-1:0] read_data_o;
   logic                  clear_i;
   logic                  busy_o;
   logic                  clr_done_o;
   logic                  ovf_o;

   modport slave (
      input  wr_en_i, acc_en_i, wr_addr_i, wr_data_i, read_addr_i, clear_i,
      output wr_ready_o, read_data_o, busy_o, clr_done_o, ovf_o
   );

   modport master (
      output wr_en_i, acc_en_i, wr_addr_i, wr_data_i, read_addr_i, clear_i,
      input  wr_ready_o, read_data_o, busy_o, clr_done_o, ovf_o
   );
endinterface

// File: rtl/conv_acc_mem.sv
// Result memory for the convolution datapath: dual-port RAM with a pipelined,
// forwarded signed read-modify-write accumulate and a full-array clear sequencer.
module conv_acc_mem #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter bit          SATURATE   = 1'b1
) (
   input logic           clk,
   input logic           rstn,
   conv_acc_mem_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned SUM_W = DATA_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, CLEAR} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  busy_q, done_q, ovf_q;
   logic [DATA_WIDTH-1:0] read_q;

   logic                  s1_valid;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [DATA_WIDTH-1:0] s1_old;
   logic                  s1_acc;

   logic                  clr_start_c, clr_we_c, clr_last_c;
   logic                  accept_c;
   logic [SUM_W-1:0]      sum_c;
   logic                  sum_ovf_c;
   logic                  wb_ovf_c;
   logic [DATA_WIDTH-1:0] result_c;

   assign accept_c = bus.wr_en_i && !busy_q && !bus.clear_i;

   // Stage-2 result of the request held in S1; also the forwarding source.
   always_comb begin
      sum_c     = {s1_old[DATA_WIDTH-1], s1_old} + {s1_data[DATA_WIDTH-1], s1_data};
      sum_ovf_c = sum_c[SUM_W-1] != sum_c[SUM_W-2];
      result_c  = s1_data;
      if (s1_acc) begin
         if (SATURATE && sum_ovf_c) result_c = sum_c[SUM_W-1] ? SMIN : SMAX;
         else                       result_c = sum_c[DATA_WIDTH-1:0];
      end
      wb_ovf_c = s1_valid && s1_acc && sum_ovf_c;
   end

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.clear_i) state_d = CLEAR;
         CLEAR:   if (cnt_q == LAST_ADDR) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clr_start_c = 1'b0;
      clr_we_c    = 1'b0;
      clr_last_c  = 1'b0;
      case (state_q)
         IDLE:  clr_start_c = bus.clear_i;
         CLEAR: begin
            clr_we_c   = 1'b1;
            clr_last_c = (cnt_q == LAST_ADDR);
         end
         default: ;
      endcase
   end

   // Control/status registers; clear acceptance wins over a same-edge overflow.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         s1_valid <= 1'b0;
      end else begin
         busy_q   <= (state_d == CLEAR);
         done_q   <= clr_last_c;
         s1_valid <= accept_c;
         if (clr_start_c)   ovf_q <= 1'b0;
         else if (wb_ovf_c) ovf_q <= 1'b1;
         if (clr_start_c)                  cnt_q <= '0;
         else if (clr_we_c && !clr_last_c) cnt_q <= cnt_q + 1'b1;
      end
   end

   // Stage 1: capture the request and its old value, forwarded from S1 on a match.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         s1_addr <= bus.wr_addr_i;
         s1_data <= bus.wr_data_i;
         s1_acc  <= bus.acc_en_i;
         if (s1_valid && (s1_addr == bus.wr_addr_i)) s1_old <= result_c;
         else                                        s1_old <= mem[bus.wr_addr_i];
      end
   end

   // Single RAM write port; clear and writeback never coincide.
   always_ff @(posedge clk) begin
      if (rstn) begin
         if (clr_we_c)      mem[cnt_q]   <= '0;
         else if (s1_valid) mem[s1_addr] <= result_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) read_q <= '0;
      else       read_q <= mem[bus.read_addr_i];
   end

   assign bus.read_data_o = read_q;
   assign bus.busy_o      = busy_q;
   assign bus.wr_ready_o  = !busy_q;
   assign bus.clr_done_o  = done_q;
   assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_conv_acc_mem.sv
// Bench for conv_acc_mem: saturating and wrap-around instances driven in lockstep,
// read data checked by a scoreboard monitor, status flags checked inline.
module tb_conv_acc_mem;
   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   conv_acc_mem_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) b1 ();
   conv_acc_mem_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) b0 ();

   assign b0.wr_en_i     = b1.wr_en_i;
   assign b0.acc_en_i    = b1.acc_en_i;
   assign b0.wr_addr_i   = b1.wr_addr_i;
   assign b0.wr_data_i   = b1.wr_data_i;
   assign b0.read_addr_i = b1.read_addr_i;
   assign b0.clear_i     = b1.clear_i;

   conv_acc_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rstn(rstn), .bus(b1));
   conv_acc_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rstn(rstn), .bus(b0));

   typedef struct {
      logic [5:0]  addr;
      logic [15:0] e_sat;
      logic [15:0] e_wrap;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic rd_vld = 1'b0;
   logic rd_vld_q = 1'b0;

   always @(posedge clk) rd_vld_q <= rd_vld;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every read issued one edge earlier is compared against the queue head.
   always @(negedge clk) begin
      if (rd_vld_q) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_unexpected: got %0h expected no read", b1.read_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("rd_sat[%0d]", e.addr), 32'(b1.read_data_o), 32'(e.e_sat));
            chk($sformatf("rd_wrap[%0d]", e.addr), 32'(b0.read_data_o), 32'(e.e_wrap));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] es, input logic [15:0] ew);
      exp_t e;
      e.addr = a; e.e_sat = es; e.e_wrap = ew;
      exp_q.push_back(e);
      b1.read_addr_i = a;
      rd_vld = 1'b1;
      tick();
      rd_vld = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic acc);
      b1.wr_en_i = 1'b1; b1.wr_addr_i = a; b1.wr_data_i = d; b1.acc_en_i = acc;
      tick();
      b1.wr_en_i = 1'b0; b1.acc_en_i = 1'b0;
   endtask

   task automatic run_clear(input bit mid_wr);
      int n;
      b1.clear_i = 1'b1;
      tick();
      b1.clear_i = 1'b0;
      b1.wr_en_i = 1'b0;
      n = 0;
      while (b1.busy_o && n < 200) begin
         chk("wr_ready_busy", 32'(b1.wr_ready_o), 32'd0);
         if (mid_wr && n == 30) begin
            b1.wr_en_i = 1'b1; b1.wr_addr_i = 6'd0; b1.wr_data_i = 16'h1111; b1.acc_en_i = 1'b0;
         end else begin
            b1.wr_en_i = 1'b0;
         end
         n++;
         tick();
      end
      b1.wr_en_i = 1'b0;
      chk("busy_len", 32'(n), 32'd64);
      chk("clr_done_pulse", 32'(b1.clr_done_o), 32'd1);
      chk("ovf_after_clear_sat", 32'(b1.ovf_o), 32'd0);
      chk("ovf_after_clear_wrap", 32'(b0.ovf_o), 32'd0);
      tick();
      chk("clr_done_one_cycle", 32'(b1.clr_done_o), 32'd0);
      chk("wr_ready_idle", 32'(b1.wr_ready_o), 32'd1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      b1.wr_en_i = 1'b0; b1.acc_en_i = 1'b0; b1.wr_addr_i = '0; b1.wr_data_i = '0;
      b1.read_addr_i = '0; b1.clear_i = 1'b0;
      rstn = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;

      // 1: reset values, then clear and read back the whole array
      chk("rst_read_data", 32'(b1.read_data_o), 32'd0);
      chk("rst_busy", 32'(b1.busy_o), 32'd0);
      chk("rst_done", 32'(b1.clr_done_o), 32'd0);
      chk("rst_ovf", 32'(b1.ovf_o), 32'd0);
      chk("rst_ready", 32'(b1.wr_ready_o), 32'd1);
      run_clear(1'b0);
      for (int i = 0; i < 64; i++) rd(6'(i), 16'h0000, 16'h0000);

      // 2: plain write; read at the writeback edge sees the old value
      wr(6'd5, 16'h1234, 1'b0);
      rd(6'd5, 16'h0000, 16'h0000);
      rd(6'd5, 16'h1234, 16'h1234);

      // 3: back-to-back accumulates to one address through forwarding
      run_clear(1'b0);
      b1.wr_en_i = 1'b1; b1.acc_en_i = 1'b1; b1.wr_addr_i = 6'd3;
      b1.wr_data_i = 16'h0010; tick();
      b1.wr_data_i = 16'h0020; tick();
      b1.wr_data_i = 16'hFFF0; tick();
      b1.wr_en_i = 1'b0; b1.acc_en_i = 1'b0;
      repeat (2) tick();
      rd(6'd3, 16'h0020, 16'h0020);
      chk("ovf_acc3_sat", 32'(b1.ovf_o), 32'd0);
      chk("ovf_acc3_wrap", 32'(b0.ovf_o), 32'd0);

      // 4: positive and negative overflow, saturating vs wrapping
      run_clear(1'b0);
      wr(6'd7, 16'h7FF0, 1'b0);
      wr(6'd7, 16'h0020, 1'b1);
      repeat (2) tick();
      rd(6'd7, 16'h7FFF, 16'h8010);
      chk("ovf_pos_sat", 32'(b1.ovf_o), 32'd1);
      chk("ovf_pos_wrap", 32'(b0.ovf_o), 32'd1);
      wr(6'd8, 16'h8005, 1'b0);
      repeat (2) tick();
      wr(6'd8, 16'hFFF0, 1'b1);
      repeat (2) tick();
      rd(6'd8, 16'h8000, 16'h7FF5);

      // 5: clear beats a simultaneous write; writes during busy are dropped
      b1.wr_en_i = 1'b1; b1.wr_addr_i = 6'd9; b1.wr_data_i = 16'h5555; b1.acc_en_i = 1'b0;
      run_clear(1'b1);
      repeat (2) tick();
      rd(6'd9, 16'h0000, 16'h0000);
      rd(6'd0, 16'h0000, 16'h0000);
      rd(6'd7, 16'h0000, 16'h0000);

      // 6: reset while the clear counter is at address 20
      for (int i = 0; i < 64; i++) begin
         b1.wr_en_i = 1'b1; b1.acc_en_i = 1'b0; b1.wr_addr_i = 6'(i); b1.wr_data_i = 16'hAAAA;
         tick();
      end
      b1.wr_en_i = 1'b0;
      repeat (2) tick();
      b1.clear_i = 1'b1;
      tick();
      b1.clear_i = 1'b0;
      repeat (20) tick();
      rstn = 1'b0;
      tick();
      chk("abort_busy", 32'(b1.busy_o), 32'd0);
      chk("abort_done", 32'(b1.clr_done_o), 32'd0);
      rstn = 1'b1;
      tick();
      chk("abort_no_done", 32'(b1.clr_done_o), 32'd0);
      chk("abort_ready", 32'(b1.wr_ready_o), 32'd1);
      for (int i = 0; i < 20; i++) rd(6'(i), 16'h0000, 16'h0000);
      for (int i = 21; i < 64; i++) rd(6'(i), 16'hAAAA, 16'hAAAA);

      repeat (3) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
